// File: rtl/hbridge_pkg.sv
// rtl/hbridge_pkg.sv - shared types and constants for the H-bridge PWM driver
package hbridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2,
    BRAKE = 2'd3
  } chan_state_t;

  localparam int DEAD_CNT_W = 16;
  localparam int LEG_FWD    = 0;
  localparam int LEG_REV    = 1;

endpackage

// File: rtl/hbridge_chan.sv
// rtl/hbridge_chan.sv - one H-bridge channel: FSM, dead-time counter, duty latch, output register
// Brake state is reachable only when HBRIDGE_BRAKE_EN is defined.
module hbridge_chan
  import hbridge_pkg::*;
#(
  parameter int DUTY_W   = 8,
  parameter int DEADTIME = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] cnt,
  input  logic              lat_en,
  input  logic [DUTY_W-1:0] duty,
  input  logic              dir,
`ifdef HBRIDGE_BRAKE_EN
  input  logic              brake,
`endif
  output logic [1:0]        out,
  output logic              busy
);

  localparam logic [DEAD_CNT_W-1:0] DEAD_LOAD = DEAD_CNT_W'(DEADTIME - 1);

  chan_state_t             state, state_nx;
  logic [DEAD_CNT_W-1:0]   dead_cnt, dead_cnt_nx;
  logic                    dir_q, dir_q_nx;
  logic [DUTY_W-1:0]       duty_lat, duty_cur;
  logic                    pwm;
  logic                    brake_req;
  logic [1:0]              out_nx;
  logic                    busy_nx;

  // At cnt == 0 the incoming duty is used directly so the new period starts clean.
  assign duty_cur = lat_en ? duty : duty_lat;
  assign pwm      = (cnt < duty_cur);

`ifdef HBRIDGE_BRAKE_EN
  assign brake_req = brake;
`else
  assign brake_req = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    dead_cnt_nx = dead_cnt;
    dir_q_nx    = dir_q;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nx = DRIVE;
          dir_q_nx = dir;
        end
        DRIVE: begin
          if (brake_req) begin
            state_nx = BRAKE;
          end else if (dir != dir_q) begin
            state_nx    = DEAD;
            dead_cnt_nx = DEAD_LOAD;
            dir_q_nx    = dir;
          end
        end
        DEAD: begin
          if (brake_req) begin
            state_nx = BRAKE;
          end else if (dir != dir_q) begin
            dead_cnt_nx = DEAD_LOAD;
            dir_q_nx    = dir;
          end else if (dead_cnt == '0) begin
            state_nx = DRIVE;
          end else begin
            dead_cnt_nx = dead_cnt - DEAD_CNT_W'(1);
          end
        end
        BRAKE: begin
          if (!brake_req) begin
            state_nx    = DEAD;
            dead_cnt_nx = DEAD_LOAD;
            dir_q_nx    = dir;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so out/busy line up with the state register.
  always_comb begin
    out_nx  = 2'b00;
    busy_nx = 1'b0;
    case (state_nx)
      DRIVE: begin
        out_nx[LEG_FWD] = pwm & ~dir_q_nx;
        out_nx[LEG_REV] = pwm & dir_q_nx;
      end
      DEAD:    busy_nx = 1'b1;
      BRAKE:   out_nx  = 2'b11;
      default: out_nx  = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dead_cnt <= '0;
      dir_q    <= 1'b0;
      duty_lat <= '0;
      out      <= 2'b00;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      dead_cnt <= dead_cnt_nx;
      dir_q    <= dir_q_nx;
      if (lat_en) duty_lat <= duty;
      out      <= out_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: rtl/hbridge_pwm_ctrl.sv
// rtl/hbridge_pwm_ctrl.sv - multi-channel H-bridge PWM driver with direction-change dead-time
// Optional brake port and state via HBRIDGE_BRAKE_EN.
module hbridge_pwm_ctrl
  import hbridge_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DUTY_W   = 8,
  parameter int DEADTIME = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [CHANNELS*DUTY_W-1:0] duty,
  input  logic [CHANNELS-1:0]        dir,
`ifdef HBRIDGE_BRAKE_EN
  input  logic [CHANNELS-1:0]        brake,
`endif
  output logic [2*CHANNELS-1:0]      out,
  output logic [CHANNELS-1:0]        busy
);

  // Period is 2**DUTY_W-1 so an all-ones duty stays high for the whole period.
  localparam logic [DUTY_W-1:0] CNT_MAX = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [DUTY_W-1:0] cnt;
  logic              lat_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DUTY_W'(1);
    end
  end

  assign lat_en = (cnt == '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    hbridge_chan #(
      .DUTY_W   (DUTY_W),
      .DEADTIME (DEADTIME)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .cnt    (cnt),
      .lat_en (lat_en),
      .duty   (duty[i*DUTY_W +: DUTY_W]),
      .dir    (dir[i]),
`ifdef HBRIDGE_BRAKE_EN
      .brake  (brake[i]),
`endif
      .out    (out[2*i +: 2]),
      .busy   (busy[i])
    );
  end

endmodule
